// File: rtl/exception_source_tracker.sv
// -----------------------------------------------------------------------------
// exception_source_tracker
//
// Per-ID lookup table recording which exception source unit owns each
// in-flight instruction. The table is written at issue and read with the
// next-to-retire ID, so the global control unit receives the owning unit of
// its oldest instruction one cycle later, aligned with retire_ids[0].
// During the global init-clear phase the table is swept back to defaults.
//
// Optional feature macro: EXC_TRACKER_BYPASS_EN
//   defined   : same-cycle issue/retire writes to the looked-up ID are
//               forwarded to the registered outputs.
//   undefined : outputs show the table contents before that cycle's writes.
//
// Ports:
//   clk                    in   clock, rising edge
//   rst                    in   synchronous active-high reset
//   issue_valid            in   instruction issued this cycle
//   issue_id               in   ID of the issuing instruction
//   issue_can_except       in   issuing instruction can raise an exception
//   issue_unit             in   owning exception source (if it can except)
//   retire_valid           in   instruction retired this cycle
//   retire_id              in   retired ID
//   retire_id_next         in   oldest ID for the next cycle
//   init_clear             in   global init-clear phase active
//   current_exception_unit out  owning unit of the oldest ID (registered)
//   current_entry_valid    out  oldest ID has a live entry (registered)
//   clear_done             out  sweep complete, sticky until next init_clear rise
// -----------------------------------------------------------------------------
module exception_source_tracker #(
  parameter int  NUM_IDS        = 32,
  parameter int  NUM_SOURCES    = 3,
  parameter int  DEFAULT_SOURCE = 0,
  localparam int ID_W           = $clog2(NUM_IDS),
  localparam int SRC_W          = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [ID_W-1:0]  issue_id,
  input  logic             issue_can_except,
  input  logic [SRC_W-1:0] issue_unit,
  input  logic             retire_valid,
  input  logic [ID_W-1:0]  retire_id,
  input  logic [ID_W-1:0]  retire_id_next,
  input  logic             init_clear,
  output logic [SRC_W-1:0] current_exception_unit,
  output logic             current_entry_valid,
  output logic             clear_done
);

  localparam logic [SRC_W-1:0] DEFAULT_UNIT = SRC_W'(DEFAULT_SOURCE);
  localparam logic [ID_W:0]    SWEEP_LAST   = (ID_W+1)'(NUM_IDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_r, state_s;
  logic [ID_W:0]    sweep_ctr_r, sweep_ctr_s;
  logic             clear_done_r, clear_done_s;
  logic             init_clear_q_r;

  logic [SRC_W-1:0] unit_table_r [NUM_IDS];
  logic [NUM_IDS-1:0] valid_r, valid_next_s;

  logic             init_rise_s;
  logic             clear_busy_s;
  logic             issue_we_s;
  logic [SRC_W-1:0] issue_data_s;
  logic [ID_W-1:0]  sweep_idx_s;
  logic [SRC_W-1:0] lookup_unit_s;
  logic             lookup_valid_s;

  // Edge detector history for init_clear. It follows the input even during
  // reset so a level held across reset is not mistaken for a fresh rise.
  always_ff @(posedge clk) begin
    init_clear_q_r <= init_clear;
  end

  // Issue/sweep qualification and the value an issue writes into the table.
  always_comb begin
    init_rise_s  = init_clear & ~init_clear_q_r;
    clear_busy_s = (state_r == ST_SWEEP);
    issue_we_s   = issue_valid & ~clear_busy_s;
    sweep_idx_s  = sweep_ctr_r[ID_W-1:0];
    if (issue_can_except) begin
      issue_data_s = issue_unit;
    end else begin
      issue_data_s = DEFAULT_UNIT;
    end
  end

  // Clear FSM next-state logic.
  always_comb begin
    state_s      = state_r;
    sweep_ctr_s  = sweep_ctr_r;
    clear_done_s = clear_done_r;
    case (state_r)
      ST_IDLE: begin
        if (init_rise_s) begin
          state_s      = ST_SWEEP;
          sweep_ctr_s  = '0;
          clear_done_s = 1'b0;
        end else begin
          state_s      = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        // Runs to completion regardless of init_clear.
        sweep_ctr_s = sweep_ctr_r + (ID_W+1)'(1);
        if (sweep_ctr_r == SWEEP_LAST) begin
          state_s      = ST_DONE;
          clear_done_s = 1'b1;
        end else begin
          state_s      = ST_SWEEP;
        end
      end
      ST_DONE: begin
        if (!init_clear) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s      = ST_IDLE;
        sweep_ctr_s  = '0;
        clear_done_s = 1'b0;
      end
    endcase
  end

  // Clear FSM state, sweep counter and sticky done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      sweep_ctr_r  <= '0;
      clear_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      sweep_ctr_r  <= sweep_ctr_s;
      clear_done_r <= clear_done_s;
    end
  end

  // Next valid vector: retire clears, a same-ID issue overrides the retire,
  // and the sweep clears its entry (issues are dropped while sweeping).
  always_comb begin
    valid_next_s = valid_r;
    if (retire_valid) begin
      valid_next_s[retire_id] = 1'b0;
    end else begin
      valid_next_s = valid_next_s;
    end
    if (issue_we_s) begin
      valid_next_s[issue_id] = 1'b1;
    end else begin
      valid_next_s = valid_next_s;
    end
    if (clear_busy_s) begin
      valid_next_s[sweep_idx_s] = 1'b0;
    end else begin
      valid_next_s = valid_next_s;
    end
  end

  // Valid flags, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else begin
      valid_r <= valid_next_s;
    end
  end

  // Unit table: no reset so it can map onto distributed RAM; single write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clear_busy_s) begin
        unit_table_r[sweep_idx_s] <= DEFAULT_UNIT;
      end else if (issue_we_s) begin
        unit_table_r[issue_id] <= issue_data_s;
      end
    end
  end

  // Lookup of the next oldest ID, optionally forwarding this cycle's writes.
  always_comb begin
    lookup_unit_s  = unit_table_r[retire_id_next];
    lookup_valid_s = valid_r[retire_id_next];
`ifdef EXC_TRACKER_BYPASS_EN
    if (issue_we_s && (issue_id == retire_id_next)) begin
      lookup_unit_s  = issue_data_s;
      lookup_valid_s = 1'b1;
    end else if (retire_valid && (retire_id == retire_id_next)) begin
      lookup_unit_s  = unit_table_r[retire_id_next];
      lookup_valid_s = 1'b0;
    end else begin
      lookup_unit_s  = unit_table_r[retire_id_next];
      lookup_valid_s = valid_r[retire_id_next];
    end
`else
    if (issue_we_s && (issue_id == retire_id_next)) begin
      // Same-cycle overlap is not forwarded; the new entry shows next cycle.
      lookup_unit_s  = unit_table_r[retire_id_next];
      lookup_valid_s = valid_r[retire_id_next];
    end else begin
      lookup_unit_s  = unit_table_r[retire_id_next];
      lookup_valid_s = valid_r[retire_id_next];
    end
`endif
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      current_exception_unit <= '0;
      current_entry_valid    <= 1'b0;
    end else begin
      current_exception_unit <= lookup_unit_s;
      current_entry_valid    <= lookup_valid_s;
    end
  end

  assign clear_done = clear_done_r;

endmodule

// File: tb/tb_exception_source_tracker.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for exception_source_tracker. A stimulus process drives
// inputs, evaluates a behavioural model of the tracker and queues the
// expected outputs; a monitor process compares them when they fall due.
// -----------------------------------------------------------------------------
module tb_exception_source_tracker;

  localparam int NUM_IDS = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [4:0] issue_id;
  logic       issue_can_except;
  logic [1:0] issue_unit;
  logic       retire_valid;
  logic [4:0] retire_id;
  logic [4:0] retire_id_next;
  logic       init_clear;
  logic [1:0] current_exception_unit;
  logic       current_entry_valid;
  logic       clear_done;

  always #5 clk = ~clk;

  exception_source_tracker dut (
    .clk                    (clk),
    .rst                    (rst),
    .issue_valid            (issue_valid),
    .issue_id               (issue_id),
    .issue_can_except       (issue_can_except),
    .issue_unit             (issue_unit),
    .retire_valid           (retire_valid),
    .retire_id              (retire_id),
    .retire_id_next         (retire_id_next),
    .init_clear             (init_clear),
    .current_exception_unit (current_exception_unit),
    .current_entry_valid    (current_entry_valid),
    .clear_done             (clear_done)
  );

  typedef struct {
    int   due;
    int   unit;
    bit   known;
    bit   valid;
    bit   done;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  int   m_unit  [NUM_IDS];
  bit   m_known [NUM_IDS];
  bit   m_valid [NUM_IDS];
  bit   m_sweeping = 0;
  int   m_sweep_left = 0;
  int   m_sweep_idx = 0;
  bit   m_waiting_release = 0;
  bit   m_prev_init = 0;
  bit   m_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Monitor: compare every expectation once its clock edge has passed.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.known) chk("unit", int'(current_exception_unit), e.unit);
      chk("valid", int'(current_entry_valid), int'(e.valid));
      chk("clear_done", int'(clear_done), int'(e.done));
    end
  end

  // Model one clock edge with the inputs currently driven, queue the result,
  // then advance to just after that edge.
  task automatic step();
    exp_t e;
    bit   acc;
    int   nv;
    int   nx;
    e.due = cyc + 1;
    nx = int'(retire_id_next);
    if (rst) begin
      e.unit = 0; e.known = 1; e.valid = 0;
      for (int i = 0; i < NUM_IDS; i++) m_valid[i] = 0;
      m_sweeping = 0; m_waiting_release = 0; m_done = 0;
    end else begin
      acc = issue_valid && !m_sweeping;
      nv  = issue_can_except ? int'(issue_unit) : 0;
      e.unit = m_unit[nx]; e.known = m_known[nx]; e.valid = m_valid[nx];
`ifdef EXC_TRACKER_BYPASS_EN
      if (acc && int'(issue_id) == nx) begin
        e.unit = nv; e.known = 1; e.valid = 1;
      end else if (retire_valid && int'(retire_id) == nx) begin
        e.valid = 0;
      end
`endif
      if (retire_valid) m_valid[retire_id] = 0;
      if (acc) begin
        m_unit[issue_id] = nv; m_known[issue_id] = 1; m_valid[issue_id] = 1;
      end
      if (m_sweeping) begin
        m_unit[m_sweep_idx] = 0; m_known[m_sweep_idx] = 1; m_valid[m_sweep_idx] = 0;
        m_sweep_idx++;
        m_sweep_left--;
        if (m_sweep_left == 0) begin
          m_sweeping = 0; m_waiting_release = 1; m_done = 1;
        end
      end else if (m_waiting_release) begin
        if (!init_clear) m_waiting_release = 0;
      end else if (init_clear && !m_prev_init) begin
        m_sweeping = 1; m_sweep_left = NUM_IDS; m_sweep_idx = 0; m_done = 0;
      end
    end
    m_prev_init = init_clear;
    e.done = m_done;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    issue_valid = 0; issue_id = 0; issue_can_except = 0; issue_unit = 0;
    retire_valid = 0; retire_id = 0;
  endtask

  task automatic issue(input int id, input bit ce, input int unit);
    issue_valid = 1; issue_id = 5'(id); issue_can_except = ce; issue_unit = 2'(unit);
  endtask

  int first_done;

  initial begin
    for (int i = 0; i < NUM_IDS; i++) begin
      m_unit[i] = 0; m_known[i] = 0; m_valid[i] = 0;
    end
    quiet();
    rst = 1; init_clear = 0; retire_id_next = 0;
    repeat (3) step();
    rst = 0;
    step();

    // Full sweep with init_clear held 40 cycles; issues during it are dropped.
    init_clear = 1;
    step();
    first_done = -1;
    for (int i = 0; i < 39; i++) begin
      quiet();
      retire_id_next = 5'($urandom_range(0, 31));
      if (i == 4) issue(10, 1, 2);
      else if ($urandom_range(0, 2) == 0) issue($urandom_range(0, 31), 1, 1);
      step();
      if (clear_done && first_done < 0) first_done = i + 1;
    end
    chk("sweep_length", first_done, NUM_IDS);
    quiet();
    init_clear = 0;
    step();
    for (int i = 0; i < NUM_IDS; i++) begin
      retire_id_next = 5'(i);
      step();
    end

    // Directed: issue 5 unit 2, then look it up.
    issue(5, 1, 2); retire_id_next = 0; step();
    quiet(); retire_id_next = 5; step(); step();
    // Non-excepting issue records the default unit; retire then invalidates.
    issue(7, 0, 2); step();
    quiet(); retire_id_next = 7; step();
    retire_valid = 1; retire_id = 7; step();
    quiet(); step(); step();
    // Same-cycle issue and lookup of ID 3.
    issue(3, 1, 1); retire_id_next = 3; step();
    quiet(); step(); step();
    // Same-cycle issue and retire of ID 9.
    issue(9, 1, 2); retire_valid = 1; retire_id = 9; retire_id_next = 0; step();
    quiet(); retire_id_next = 9; step(); step();
    // Entry 10 after the sweep.
    retire_id_next = 10; step(); step();

    // Randomized traffic with occasional short init_clear pulses.
    for (int i = 0; i < 700; i++) begin
      quiet();
      init_clear = ((i % 230) >= 100) && ((i % 230) < 104);
      if ($urandom_range(0, 1) == 1)
        issue($urandom_range(0, 31), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) begin
        retire_valid = 1; retire_id = 5'($urandom_range(0, 31));
      end
      case ($urandom_range(0, 3))
        0: retire_id_next = issue_id;
        1: retire_id_next = retire_id;
        default: retire_id_next = 5'($urandom_range(0, 31));
      endcase
      step();
    end
    quiet(); init_clear = 0;
    repeat (40) step();

    // Reset at sweep cycle 12 with init_clear still held.
    init_clear = 1; retire_id_next = 2; step();
    repeat (12) step();
    rst = 1; step();
    rst = 0;
    repeat (10) step();
    init_clear = 0; step();
    init_clear = 1;
    repeat (40) step();
    init_clear = 0;
    for (int i = 0; i < 4; i++) begin
      retire_id_next = 5'($urandom_range(0, 31));
      step();
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #6;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exception_source_tracker.md
# exception_source_tracker

Per-ID lookup table that records which exception source unit owns each in-flight instruction, and presents the owning unit index for the next-to-retire ID to the global control unit as `current_exception_unit`. Sits upstream of the global control unit: written at issue, read with `retire_ids_next[0]`. The global control unit can then index exception interfaces with one lookup instead of comparing every source. Also sweeps its table clean during the global init-clear phase.

## Interface
- `NUM_IDS`, 32: in-flight ID count, power of two; `ID_W = $clog2(NUM_IDS)`.
- `NUM_SOURCES`, 3: exception sources; `SRC_W = max(1, $clog2(NUM_SOURCES))`.
- `DEFAULT_SOURCE`, 0: unit index recorded for instructions that cannot raise exceptions.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  instruction issued this cycle.
- `issue_id`  in  ID_W  ID of the issuing instruction.
- `issue_can_except`  in  1  instruction can raise an exception.
- `issue_unit`  in  SRC_W  exception source owning the instruction; used only when `issue_can_except`.
- `retire_valid`  in  1  instruction retired this cycle.
- `retire_id`  in  ID_W  retired ID.
- `retire_id_next`  in  ID_W  next-cycle oldest ID (`retire_ids_next[0]`).
- `init_clear`  in  1  global init-clear phase active.
- `current_exception_unit`  out  SRC_W  owning unit of oldest ID, registered.
- `current_entry_valid`  out  1  oldest ID has a live table entry, registered.
- `clear_done`  out  1  table sweep complete, sticky until next `init_clear` rise or reset.

## Operation
- Storage: `unit_table[NUM_IDS]` (SRC_W, no reset, LUTRAM-friendly); `valid[NUM_IDS]` flops, reset to 0.
- Issue write, when `issue_valid & ~clear_busy`: `unit_table[issue_id] <= issue_can_except ? issue_unit : DEFAULT_SOURCE`; `valid[issue_id] <= 1`.
- Retire, when `retire_valid`: `valid[retire_id] <= 0`. If the same cycle also issues the same ID, the issue write wins and `valid` stays 1.
- Lookup: every cycle, `current_exception_unit <= unit_table[retire_id_next]` and `current_entry_valid <= valid[retire_id_next]`.
- Clear FSM states:
  - IDLE → SWEEP on the rising edge of `init_clear`: `clear_done <= 0`, `sweep_ctr <= 0`.
  - SWEEP, each cycle: write `unit_table[sweep_ctr] <= DEFAULT_SOURCE` and `valid[sweep_ctr] <= 0`, then `sweep_ctr++`.
  - At `sweep_ctr == NUM_IDS-1`: → DONE, `clear_done <= 1`.
  - DONE → IDLE when `init_clear` deasserts.
  - `clear_busy` = state is SWEEP.
- Issue writes during SWEEP are dropped. Retire clears during SWEEP are harmless.
- `init_clear` deasserting mid-sweep does not abort it; the sweep always completes all NUM_IDS entries.
- `sweep_ctr` is ID_W+1 bits wide. Increments wrap naturally and are never observed past NUM_IDS-1.

## Timing
- Reset values: `current_exception_unit = 0`, `current_entry_valid = 0`, `clear_done = 0`, state IDLE, `sweep_ctr = 0`, all `valid = 0`.
- Lookup latency is 1 cycle: the address presented in cycle t appears on the outputs in cycle t+1, aligned with the global control unit's `retire_ids[0]`.
- Write-to-read same cycle: an issue to ID X and `retire_id_next == X` in cycle t; behaviour depends on `EXC_TRACKER_BYPASS_EN` (see Configuration).
- Sweep length: `clear_done` rises exactly NUM_IDS cycles after the cycle in which the `init_clear` rise is sampled.
- Reset mid-sweep: returns to IDLE with `clear_done = 0`. A fresh `init_clear` rise is required to sweep again.

## Configuration
- `EXC_TRACKER_BYPASS_EN`
  - Defined: a same-cycle issue write whose `issue_id == retire_id_next` forwards the new unit and `valid = 1` to the outputs at t+1.
  - Defined, retire clear to the same address: forwards `valid = 0`, with issue priority as above.
  - Undefined: outputs at t+1 show the pre-write table contents, and the global control unit must not rely on same-cycle issue/oldest overlap.

## Test plan
- Reset, then `init_clear` held for 40 cycles → `clear_done` rises on cycle 32 after the rise is sampled; reading all IDs returns unit 0, valid 0.
- Issue ID 5 with `issue_can_except = 1`, unit 2; next cycle set `retire_id_next = 5` → one cycle later `current_exception_unit = 2`, `current_entry_valid = 1`.
- Issue ID 7 with `issue_can_except = 0` → lookup of 7 returns `DEFAULT_SOURCE` (0), valid 1. Retire 7, then look up 7 → valid 0.
- Same cycle: issue ID 3 unit 1 with `retire_id_next = 3` → with the bypass macro, t+1 shows unit 1, valid 1; without it, t+1 shows the prior contents and t+2 (address held) shows unit 1.
- Same cycle: issue and retire on ID 9 → `valid[9]` stays 1; issue during SWEEP to ID 10 → entry 10 reads unit 0, valid 0 after `clear_done`.
- Assert `rst` for one cycle at sweep cycle 12 → `clear_done` stays 0 and the outputs read 0. A new `init_clear` rise completes in 32 cycles.
